// File: rtl/ctrl_pipe_pkg.sv
// Shared control-word and stage types for the EX/MEM/WB control pipeline.
// Package name control_itf is what the rest of the core imports.
package control_itf;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic       dcache_read;
    logic       dcache_write;
    logic       load_regfile;
  } ctrl_word;

  typedef struct packed {
    logic       valid;
    ctrl_word   ctrl;
    logic [4:0] rd;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // An invalid ID slot always enters the pipe as a clean bubble.
  function automatic stage_t make_stage(logic valid, ctrl_word ctrl, logic [4:0] rd);
    stage_t s;
    s = STAGE_BUBBLE;
    if (valid) begin
      s.valid = 1'b1;
      s.ctrl  = ctrl;
      s.rd    = rd;
    end
    return s;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: bubble insertion wins over load, otherwise hold.
module ctrl_stage_reg
  import control_itf::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= STAGE_BUBBLE;
    end else if (bubble) begin
      q <= STAGE_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use interlock, dcache wait and flush.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
  import control_itf::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  ctrl_word   id_ctrl,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       flush,
  input  logic       dcache_resp,
  output ctrl_word   ex_ctrl,
  output ctrl_word   mem_ctrl,
  output ctrl_word   wb_ctrl,
  output logic       ex_valid,
  output logic       mem_valid,
  output logic       wb_valid,
  output logic [4:0] ex_rd,
  output logic [4:0] mem_rd,
  output logic [4:0] wb_rd,
  output logic       stall_id,
  output logic       dcache_read,
  output logic       dcache_write,
`ifdef CTRL_PIPE_PERF_EN
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_memwait_cnt,
`endif
  output logic       load_regfile
);

  stage_t ex_q, mem_q, wb_q, id_stage;
  logic   mem_wait, load_use;
  logic   ex_load, ex_bubble, mem_load, wb_load, wb_bubble;

  assign id_stage = make_stage(id_valid, id_ctrl, id_rd);

  always_comb begin
    mem_wait  = mem_q.valid & (mem_q.ctrl.dcache_read | mem_q.ctrl.dcache_write) & ~dcache_resp;
    load_use  = ex_q.valid & ex_q.ctrl.dcache_read & (ex_q.rd != 5'd0) & id_valid &
                ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));
    ex_load   = 1'b0;
    ex_bubble = 1'b0;
    mem_load  = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    stall_id  = 1'b0;
    if (mem_wait) begin
      // EX and MEM hold; flush and load_use are ignored while the dcache is busy.
      wb_bubble = 1'b1;
      stall_id  = 1'b1;
    end else begin
      mem_load = 1'b1;
      wb_load  = 1'b1;
      if (flush) begin
        ex_bubble = 1'b1;
      end else if (load_use) begin
        ex_bubble = 1'b1;
        stall_id  = 1'b1;
      end else begin
        ex_load = 1'b1;
      end
    end
  end

  ctrl_stage_reg u_ex (
    .clk(clk), .rst(rst), .load(ex_load), .bubble(ex_bubble), .d(id_stage), .q(ex_q)
  );
  ctrl_stage_reg u_mem (
    .clk(clk), .rst(rst), .load(mem_load), .bubble(1'b0), .d(ex_q), .q(mem_q)
  );
  ctrl_stage_reg u_wb (
    .clk(clk), .rst(rst), .load(wb_load), .bubble(wb_bubble), .d(mem_q), .q(wb_q)
  );

  assign ex_valid     = ex_q.valid;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_rd        = ex_q.rd;
  assign mem_valid    = mem_q.valid;
  assign mem_ctrl     = mem_q.ctrl;
  assign mem_rd       = mem_q.rd;
  assign wb_valid     = wb_q.valid;
  assign wb_ctrl      = wb_q.ctrl;
  assign wb_rd        = wb_q.rd;
  assign dcache_read  = mem_q.valid & mem_q.ctrl.dcache_read;
  assign dcache_write = mem_q.valid & mem_q.ctrl.dcache_write;
  assign load_regfile = wb_q.valid & wb_q.ctrl.load_regfile & (wb_q.rd != 5'd0);

`ifdef CTRL_PIPE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt  <= '0;
      perf_memwait_cnt <= '0;
    end else begin
      if (ex_bubble && (perf_bubble_cnt != 32'hFFFF_FFFF))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (mem_wait && (perf_memwait_cnt != 32'hFFFF_FFFF))
        perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized plus directed bench for ctrl_pipe against a stage-list reference model.
module tb_ctrl_pipe;
  import control_itf::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  ctrl_word   id_ctrl = '0;
  logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       flush = 1'b0;
  logic       dcache_resp = 1'b1;
  ctrl_word   ex_ctrl, mem_ctrl, wb_ctrl;
  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       stall_id, dcache_read, dcache_write, load_regfile;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_memwait_cnt;
`endif

  int total = 0;
  int bad = 0;

  ctrl_pipe dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .flush(flush), .dcache_resp(dcache_resp),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .stall_id(stall_id), .dcache_read(dcache_read), .dcache_write(dcache_write),
`ifdef CTRL_PIPE_PERF_EN
    .perf_bubble_cnt(perf_bubble_cnt), .perf_memwait_cnt(perf_memwait_cnt),
`endif
    .load_regfile(load_regfile)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m[0]=EX, m[1]=MEM, m[2]=WB, shifted as whole instruction records.
  stage_t m [3];
  logic [31:0] m_bub = 0, m_mw = 0;

  function automatic logic ref_mem_wait();
    return m[1].valid && (m[1].ctrl.dcache_read || m[1].ctrl.dcache_write) && !dcache_resp;
  endfunction

  function automatic logic ref_load_use();
    logic hit;
    hit = (id_uses_rs1 && id_rs1 == m[0].rd) || (id_uses_rs2 && id_rs2 == m[0].rd);
    return m[0].valid && m[0].ctrl.dcache_read && m[0].rd != 0 && id_valid && hit;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m[i] <= STAGE_BUBBLE;
      m_bub <= 0;
      m_mw  <= 0;
    end else if (ref_mem_wait()) begin
      m[2] <= STAGE_BUBBLE;
      if (m_mw != 32'hFFFF_FFFF) m_mw <= m_mw + 1;
    end else begin
      m[2] <= m[1];
      m[1] <= m[0];
      if (flush || ref_load_use()) begin
        m[0] <= STAGE_BUBBLE;
        if (m_bub != 32'hFFFF_FFFF) m_bub <= m_bub + 1;
      end else begin
        m[0] <= id_valid ? stage_t'{valid: 1'b1, ctrl: id_ctrl, rd: id_rd} : STAGE_BUBBLE;
      end
    end
  end

  task automatic check_all();
    logic mw;
    mw = ref_mem_wait();
    chk("ex_valid", 32'(ex_valid), 32'(m[0].valid));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m[0].ctrl));
    chk("ex_rd", 32'(ex_rd), 32'(m[0].rd));
    chk("mem_valid", 32'(mem_valid), 32'(m[1].valid));
    chk("mem_ctrl", 32'(mem_ctrl), 32'(m[1].ctrl));
    chk("mem_rd", 32'(mem_rd), 32'(m[1].rd));
    chk("wb_valid", 32'(wb_valid), 32'(m[2].valid));
    chk("wb_ctrl", 32'(wb_ctrl), 32'(m[2].ctrl));
    chk("wb_rd", 32'(wb_rd), 32'(m[2].rd));
    chk("stall_id", 32'(stall_id), 32'(mw || (!flush && ref_load_use())));
    chk("dcache_read", 32'(dcache_read), 32'(m[1].valid && m[1].ctrl.dcache_read));
    chk("dcache_write", 32'(dcache_write), 32'(m[1].valid && m[1].ctrl.dcache_write));
    chk("load_regfile", 32'(load_regfile), 32'(m[2].valid && m[2].ctrl.load_regfile && m[2].rd != 0));
`ifdef CTRL_PIPE_PERF_EN
    chk("perf_bubble", perf_bubble_cnt, m_bub);
    chk("perf_memwait", perf_memwait_cnt, m_mw);
`endif
  endtask

  // Drive one cycle's inputs at negedge, then compare shortly after.
  task automatic cyc(input logic iv, input ctrl_word c, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                     input logic u2, input logic fl, input logic resp);
    @(negedge clk);
    id_valid = iv; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; flush = fl; dcache_resp = resp;
    #1;
    check_all();
  endtask

  task automatic idle(input logic resp);
    cyc(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, resp);
  endtask

  ctrl_word op_imm, ld, add;
  int stalls, wb_bubbles;

  initial begin
    op_imm = '0; op_imm.alu_op = 4'h1; op_imm.alu_src_imm = 1'b1; op_imm.load_regfile = 1'b1;
    ld     = '0; ld.alu_src_imm = 1'b1; ld.dcache_read = 1'b1; ld.load_regfile = 1'b1;
    add    = '0; add.alu_op = 4'h2; add.load_regfile = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back op_imm x1..x3: each in WB three cycles after ID.
    for (int i = 1; i <= 3; i++) cyc(1'b1, op_imm, 5'(i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      idle(1'b1);
      chk("b2b_wb_rd", 32'(wb_rd), 32'(i));
      chk("b2b_load_rf", 32'(load_regfile), 32'd1);
    end

    // Load x5 then add reading x5: one stall cycle, add in WB one cycle late.
    cyc(1'b1, ld, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, add, 5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lu_stall", 32'(stall_id), 32'd1);
    cyc(1'b1, add, 5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("lu_stall_once", 32'(stall_id), 32'd0);
    chk("lu_ex_bubble", 32'(ex_valid), 32'd0);
    idle(1'b1); idle(1'b1);
    chk("lu_wb_early", 32'(wb_rd), 32'd0);
    idle(1'b1);
    chk("lu_wb_rd", 32'(wb_rd), 32'd6);

    // Load held in MEM for four cycles without a response.
    cyc(1'b1, ld, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, add, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    stalls = 0; wb_bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, op_imm, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      stalls += int'(stall_id);
      chk("mw_dc_read", 32'(dcache_read), 32'd1);
      chk("mw_mem_rd", 32'(mem_rd), 32'd7);
      if (i > 0) wb_bubbles += int'(!wb_valid);
    end
    idle(1'b1);
    wb_bubbles += int'(!wb_valid);
    chk("mw_stalls", 32'(stalls), 32'd4);
    chk("mw_wb_bubbles", 32'(wb_bubbles), 32'd4);

    // Flush kills the ID instruction; rd=x0 never writes.
    cyc(1'b1, op_imm, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, op_imm, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_ex_bubble", 32'(ex_valid), 32'd0);
    idle(1'b1); idle(1'b1);
    chk("flush_no_write", 32'(load_regfile), 32'd0);
    idle(1'b1);
    chk("x0_wb_valid", 32'(wb_valid), 32'd1);
    chk("x0_no_write", 32'(load_regfile), 32'd0);

    // Random traffic with small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      ctrl_word c;
      c = ctrl_word'($urandom);
      c.dcache_read  = ($urandom_range(0, 2) == 0);
      c.dcache_write = !c.dcache_read && ($urandom_range(0, 4) == 0);
      cyc(1'($urandom), c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of a dcache wait clears everything before the next edge.
    cyc(1'b1, ld, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("pre_rst_stall", 32'(stall_id), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_ex", 32'(ex_valid), 32'd0);
    chk("rst_mem", 32'(mem_valid), 32'd0);
    chk("rst_wb", 32'(wb_valid), 32'd0);
    chk("rst_dc_read", 32'(dcache_read), 32'd0);
    chk("rst_stall_mw", 32'(stall_id), 32'd0);
    chk("rst_load_rf", 32'(load_regfile), 32'd0);
`ifdef CTRL_PIPE_PERF_EN
    chk("rst_perf_bub", perf_bubble_cnt, 32'd0);
    chk("rst_perf_mw", perf_memwait_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, op_imm, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk("post_rst_wb_rd", 32'(wb_rd), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
